flatten_dense_classifier: RTL
=============================

FLATTEN_DENSE_CLASSIFIER -- requirements
Module: flatten_dense_classifier

Interface
REQ-001 Params SHALL be: NUM_CLASSES, default 5, output classes; FEAT_CH, default 16, channels per pooled beat; FEAT_POS, default 4, beats per frame; ACC_W, default 24, accumulator width.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that arms frame collection.
REQ-005 feat_valid  input  1  pooled-beat strobe from the upstream pooling control (its maxflag output).
REQ-006 feat[0..15]  input  16x8  unsigned post-ReLU pooled features for one beat.
REQ-007 w_addr  output  9  weight-memory read address.
REQ-008 w_data  input  8  signed weight/bias word, valid exactly 1 cycle after w_addr.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 class_id  output  3  winning class index, held until the next result.
REQ-011 class_valid  output  1  one-cycle pulse when class_id updates.
REQ-012 overrun  output  1  sticky flag; feat_valid was seen while in MAC/CMP.

Function
REQ-013 FSM states SHALL be IDLE, COLLECT, MAC, CMP, DONE.
REQ-014 IDLE -> COLLECT on start; start in any other state SHALL be ignored.
REQ-015 feat_valid in IDLE SHALL be ignored.
REQ-016 In COLLECT, each feat_valid SHALL store feat[ch] at buffer index pos*16+ch, where pos is a 2-bit beat counter starting at 0.
REQ-017 COLLECT -> MAC in the cycle after the 4th feat_valid; pos resets to 0.
REQ-018 Memory layout SHALL be 65 words per class at base c*65: word 0 = bias, words 1..64 = weights for features 0..63.
REQ-019 MAC per class SHALL drive w_addr = c*65+k for k = 0..64 on consecutive cycles, plus one drain cycle (66 cycles).
REQ-020 Accumulation SHALL be acc = sext(bias) + sum(zext(feature)*sext(weight)), ACC_W signed, no saturation.
REQ-021 Width rule: max |acc| < 2^23, so 24 bits SHALL be sufficient.
REQ-022 MAC -> CMP after the drain cycle.
REQ-023 CMP (1 cycle) SHALL replace best score/index when acc > best (strict); ties SHALL keep the lower index.
REQ-024 Class 0 SHALL always load best.
REQ-025 CMP -> MAC for the next class, or -> DONE after class NUM_CLASSES-1.
REQ-026 DONE (1 cycle) SHALL update class_id, pulse class_valid, then return to IDLE.
REQ-027 Latency: class_valid SHALL assert exactly NUM_CLASSES*67+1 cycles (336 at default) after the cycle sampling the 4th feat_valid.
REQ-028 overrun SHALL set on feat_valid in MAC/CMP/DONE, clear on accepted start, and SHALL NOT disturb the current computation.
REQ-029 w_addr SHALL hold 0 outside MAC.

Reset
REQ-030 rst SHALL force IDLE from any state, including mid-COLLECT or mid-MAC.
REQ-031 rst SHALL zero busy, class_id, class_valid, overrun, w_addr, counters, acc and best.
REQ-032 Feature buffer contents need not reset; they are overwritten before use.

Structure
REQ-033 NUM_CLASSES, FEAT_CH, FEAT_POS, ACC_W, WORDS_PER_CLASS=65 and the state enum SHALL live in the shared CNN package.
REQ-034 One sub-module, dense_mac_unit (8x8 signed-unsigned multiply + ACC_W accumulate with clear/enable), SHALL be instantiated.

Verification
REQ-035 All features 1; all weights 1 except class 2 = 2; biases 0 -> scores 64,64,128,64,64; class_id=2, class_valid at +336 cycles.
REQ-036 Features 255; class 0 weights -128, others 0, class 4 bias 1 -> acc0 = -2088960 (no wrap); class_id=4.
REQ-037 All scores equal (weights 0, biases 5) -> class_id=0.
REQ-038 3 feat_valid before start, then start and 4 beats -> only the post-start beats are used; result matches the reference model.
REQ-039 feat_valid pulse at MAC cycle 100 -> overrun=1, class_id unchanged vs. the clean run; next start clears overrun.
REQ-040 rst asserted mid-MAC (class 2, k=30) -> busy=0 and w_addr=0 immediately; a following full frame classifies correctly.

Source files
------------

// File: rtl/flatten_dense_classifier_pkg.sv
// Shared CNN constants and FSM encoding for the flatten + dense classifier head.
// The top and the MAC unit take their default parameters from here.
package flatten_dense_classifier_pkg;

  localparam int NUM_CLASSES     = 5;
  localparam int FEAT_CH         = 16;
  localparam int FEAT_POS        = 4;
  localparam int ACC_W           = 24;
  localparam int WORDS_PER_CLASS = FEAT_CH * FEAT_POS + 1;
  localparam int ADDR_W          = 9;
  localparam int CLASS_W         = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MAC,
    ST_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/flatten_dense_classifier_mac.sv
// Unsigned-feature x signed-weight multiply feeding a signed accumulator.
// clear with en restarts the sum at the current product (the bias is fed as 1 * bias).
module dense_mac_unit #(
  parameter int ACC_W = flatten_dense_classifier_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic [7:0]              a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_base;

  assign prod     = $signed({1'b0, a}) * b;
  assign acc_base = clear ? '0 : acc_reg;
  assign acc      = acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_base + ACC_W'(prod);
    end else if (clear) begin
      acc_reg <= '0;
    end
  end

endmodule

// File: rtl/flatten_dense_classifier.sv
// Collects FEAT_POS pooled beats, scores each class as bias + dot(features, weights)
// from an external weight memory, and reports the argmax (lowest index on ties).
module flatten_dense_classifier #(
  parameter int NUM_CLASSES = flatten_dense_classifier_pkg::NUM_CLASSES,
  parameter int FEAT_CH     = flatten_dense_classifier_pkg::FEAT_CH,
  parameter int FEAT_POS    = flatten_dense_classifier_pkg::FEAT_POS,
  parameter int ACC_W       = flatten_dense_classifier_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    feat_valid,
  input  logic [FEAT_CH-1:0][7:0] feat,
  output logic [8:0]              w_addr,
  input  logic signed [7:0]       w_data,
  output logic                    busy,
  output logic [2:0]              class_id,
  output logic                    class_valid,
  output logic                    overrun
);
  import flatten_dense_classifier_pkg::*;

  localparam int N_FEAT = FEAT_CH * FEAT_POS;
  localparam int WPC    = N_FEAT + 1;
  localparam int K_W    = $clog2(WPC + 1);
  localparam int POS_W  = (FEAT_POS > 1) ? $clog2(FEAT_POS) : 1;
  localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  state_t state_reg, state_next;

  logic [POS_W-1:0]        pos_reg;
  logic [K_W-1:0]          k_reg;
  logic [CLASS_W-1:0]      cls_reg;
  logic [ADDR_W-1:0]       base_reg;
  logic signed [ACC_W-1:0] best_reg;
  logic [CLASS_W-1:0]      best_idx_reg;
  logic [CLASS_W-1:0]      class_id_reg;
  logic                    class_valid_reg;
  logic                    overrun_reg;

  logic [7:0]              feat_buf [N_FEAT];
  logic [7:0]              feat_rd_reg;
  logic [IDX_W-1:0]        rd_idx;

  logic                    mac_clear;
  logic                    mac_en;
  logic [7:0]              mac_a;
  logic signed [ACC_W-1:0] acc;
  logic                    last_cls;
  logic                    take_new;
  logic                    last_beat;

  assign last_cls    = (cls_reg == CLASS_W'(NUM_CLASSES - 1));
  assign take_new    = (cls_reg == '0) || (acc > best_reg);
  assign last_beat   = (pos_reg == POS_W'(FEAT_POS - 1));
  assign class_id    = class_id_reg;
  assign class_valid = class_valid_reg;
  assign overrun     = overrun_reg;

  // The read is issued one cycle ahead so feat_rd_reg lines up with w_data.
  assign rd_idx = IDX_W'(k_reg - K_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    w_addr     = '0;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    mac_a      = feat_rd_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (feat_valid && last_beat) state_next = ST_MAC;
      end
      ST_MAC: begin
        if (k_reg < K_W'(WPC)) w_addr = base_reg + ADDR_W'(k_reg);
        // k=1 sees the bias word; k=2..WPC see weights; k=WPC is the drain.
        if (k_reg == K_W'(1)) begin
          mac_clear = 1'b1;
          mac_en    = 1'b1;
          mac_a     = 8'd1;
        end else if (k_reg > K_W'(1)) begin
          mac_en = 1'b1;
        end
        if (k_reg == K_W'(WPC)) state_next = ST_CMP;
      end
      ST_CMP: begin
        state_next = last_cls ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg         <= '0;
      k_reg           <= '0;
      cls_reg         <= '0;
      base_reg        <= '0;
      best_reg        <= '0;
      best_idx_reg    <= '0;
      class_id_reg    <= '0;
      class_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      class_valid_reg <= 1'b0;
      if (state_reg == ST_IDLE && start) begin
        overrun_reg <= 1'b0;
      end else if (feat_valid && (state_reg == ST_MAC || state_reg == ST_CMP ||
                                  state_reg == ST_DONE)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          pos_reg  <= '0;
          k_reg    <= '0;
          cls_reg  <= '0;
          base_reg <= '0;
        end
        ST_COLLECT: begin
          if (feat_valid) pos_reg <= last_beat ? '0 : pos_reg + POS_W'(1);
        end
        ST_MAC: begin
          k_reg <= (k_reg == K_W'(WPC)) ? '0 : k_reg + K_W'(1);
        end
        ST_CMP: begin
          if (take_new) begin
            best_reg     <= acc;
            best_idx_reg <= cls_reg;
          end
          cls_reg  <= cls_reg + CLASS_W'(1);
          base_reg <= base_reg + ADDR_W'(WPC);
          // The final comparison is folded in here so class_id is valid during DONE.
          if (last_cls) begin
            class_id_reg    <= take_new ? cls_reg : best_idx_reg;
            class_valid_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Feature buffer is fully rewritten by every frame, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_reg == ST_COLLECT && feat_valid) begin
      for (int ch = 0; ch < FEAT_CH; ch++) begin
        feat_buf[IDX_W'(int'(pos_reg) * FEAT_CH + ch)] <= feat[ch];
      end
    end
    feat_rd_reg <= feat_buf[rd_idx];
  end

  dense_mac_unit #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clear(mac_clear),
    .en   (mac_en),
    .a    (mac_a),
    .b    (w_data),
    .acc  (acc)
  );

endmodule
